// File: rtl/a2d_round_robin.sv
// Round-robin sequencer for four ADC128S channels through SPI_mstr16; two SPI
// transactions per channel. Define A2D_AVG_EN to average each capture with the held value.
module a2d_round_robin #(
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4,
    parameter logic [2:0] STEER_CH = 3'd5,
    parameter logic [2:0] BATT_CH  = 3'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic [15:0] cmd,
    output logic        wrt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT1, GAP, WAIT2} state_t;

    state_t      state;
    logic [1:0]  rr_cnt;
    logic [2:0]  chnl;
    logic [11:0] res;
    logic        unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:12];

    always_comb begin
        chnl = LFT_CH;
        case (rr_cnt)
            2'd0: chnl = LFT_CH;
            2'd1: chnl = RGHT_CH;
            2'd2: chnl = STEER_CH;
            2'd3: chnl = BATT_CH;
            default: chnl = LFT_CH;
        endcase
    end

`ifdef A2D_AVG_EN
    logic [11:0] cur;
    logic [12:0] sum;

    always_comb begin
        cur = lft_ld;
        case (rr_cnt)
            2'd0: cur = lft_ld;
            2'd1: cur = rght_ld;
            2'd2: cur = steer_pot;
            2'd3: cur = batt;
            default: cur = lft_ld;
        endcase
    end

    // 13-bit sum so the halved result can never wrap
    assign sum = {1'b0, cur} + {1'b0, rd_data[11:0]};
    assign res = sum[12:1];
`else
    assign res = rd_data[11:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_cnt    <= 2'd0;
            cmd       <= {2'b00, LFT_CH, 11'h000};
            wrt       <= 1'b0;
            cnv_cmplt <= 1'b0;
            busy      <= 1'b0;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            steer_pot <= 12'h000;
            batt      <= 12'h000;
        end else begin
            wrt       <= 1'b0;
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: if (nxt) begin
                    wrt   <= 1'b1;
                    busy  <= 1'b1;
                    cmd   <= {2'b00, chnl, 11'h000};
                    state <= WAIT1;
                end
                WAIT1: if (done) state <= GAP;
                // Second transaction repeats cmd; ADC returns the previous address' data
                GAP: begin
                    wrt   <= 1'b1;
                    state <= WAIT2;
                end
                WAIT2: if (done) begin
                    case (rr_cnt)
                        2'd0: lft_ld    <= res;
                        2'd1: rght_ld   <= res;
                        2'd2: steer_pot <= res;
                        2'd3: batt      <= res;
                        default: lft_ld <= res;
                    endcase
                    cnv_cmplt <= 1'b1;
                    busy      <= 1'b0;
                    rr_cnt    <= rr_cnt + 2'd1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_round_robin.sv
// Randomized bench for a2d_round_robin: SPI_mstr16 responder plus a per-channel
// result model indexed by rotation position.
module tb_a2d_round_robin;

    logic        clk = 1'b0;
    logic        rst;
    logic        nxt;
    logic [15:0] cmd;
    logic        wrt;
    logic        done;
    logic [15:0] rd_data;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        cnv_cmplt;
    logic        busy;

    a2d_round_robin dut (
        .clk(clk), .rst(rst), .nxt(nxt), .cmd(cmd), .wrt(wrt), .done(done),
        .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .cnv_cmplt(cnv_cmplt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // reference model: channel address per rotation slot and expected contents
    int          ch_addr [4] = '{0, 4, 5, 6};
    logic [11:0] exp_reg [4];
    int          rot;

    logic [15:0] resp_q [$];
    int          wrt_t [$];
    int          done_t [$];
    logic [15:0] cmd_log [$];
    int          lat = 20;
    int          spur_req = 0;
    int          spur_ack = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_lft"},   lft_ld,    exp_reg[0]);
        chk({tag, "_rght"},  rght_ld,   exp_reg[1]);
        chk({tag, "_steer"}, steer_pot, exp_reg[2]);
        chk({tag, "_batt"},  batt,      exp_reg[3]);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_reg[i] = 12'h000;
        rot = 0;
    endtask

    // SPI_mstr16 stand-in: done arrives lat cycles after each wrt
    initial begin
        int  dly;
        bit  pend;
        done = 1'b0; rd_data = 16'h0000; pend = 0; dly = 0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (rst) pend = 0;
            else if (spur_req != spur_ack) begin
                spur_ack++;
                done    = 1'b1;
                rd_data = 16'($urandom);
            end else if (wrt) begin
                wrt_t.push_back(cyc);
                cmd_log.push_back(cmd);
                pend = 1;
                dly  = lat;
            end else if (pend) begin
                dly--;
                if (dly == 0) begin
                    pend    = 0;
                    done    = 1'b1;
                    rd_data = (resp_q.size() > 0) ? resp_q.pop_front() : 16'h0000;
                    done_t.push_back(cyc);
                end
            end
        end
    end

    task automatic convert(input logic [15:0] r1, input logic [15:0] r2, input int l, input bit poke);
        int          n_t;
        bit          seen;
        logic [15:0] ecmd;
        ecmd = 16'(ch_addr[rot] * 2048);
        resp_q.push_back(r1);
        resp_q.push_back(r2);
        wrt_t.delete(); done_t.delete(); cmd_log.delete();
        lat = l;
        @(negedge clk); nxt = 1'b1; n_t = cyc;
        @(negedge clk); nxt = 1'b0;
        chk("busy_set", busy, 1);
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (cnv_cmplt) begin
                seen = 1;
                nxt  = 1'b0;
            end else begin
                nxt = poke && ($urandom_range(0, 2) == 0);
            end
        end
        nxt = 1'b0;
        chk("cc_seen", seen, 1);
`ifdef A2D_AVG_EN
        exp_reg[rot] = 12'((int'(exp_reg[rot]) + int'(r2[11:0])) / 2);
`else
        exp_reg[rot] = r2[11:0];
`endif
        rot = (rot + 1) % 4;
        if (done_t.size() > 0) chk("cc_lat", 32'(cyc - done_t[done_t.size()-1]), 1);
        chk_regs("cap");
        chk("busy_clr", busy, 0);
        chk("cmd_hold", cmd, ecmd);
        @(negedge clk);
        chk("cc_pulse", cnv_cmplt, 0);
        repeat (3) @(negedge clk);
        chk("n_wrt", wrt_t.size(), 2);
        chk("n_done", done_t.size(), 2);
        if (wrt_t.size() == 2 && done_t.size() == 2) begin
            chk("wrt_after_nxt", 32'(wrt_t[0] - n_t), 1);
            chk("gap_cycle", 32'(wrt_t[1] - done_t[0]), 2);
            chk("cmd_tx1", cmd_log[0], ecmd);
            chk("cmd_tx2", cmd_log[1], ecmd);
        end
    endtask

    initial begin
        rst = 1'b1; nxt = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_regs("rst");
        chk("rst_wrt", wrt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cc", cnv_cmplt, 0);
        chk("rst_cmd", cmd, 16'h0000);
        rst = 1'b0;
        @(negedge clk);

        // single conversion, then one full rotation and a wrap back to channel 0
        convert(16'h0C00, 16'hFABC, 20, 0);
        convert(16'($urandom), 16'h0222, 20, 0);
        convert(16'($urandom), 16'h0333, 20, 0);
        convert(16'($urandom), 16'h0444, 20, 0);
        convert(16'($urandom), 16'h0111, 20, 0);
        convert(16'($urandom), 16'hF555, 7, 0);

        // nxt while busy must be dropped
        convert(16'($urandom), 16'($urandom), 12, 1);
        convert(16'($urandom), 16'($urandom), 3, 1);

        // done while IDLE is ignored
        spur_req++;
        repeat (3) begin
            @(negedge clk);
            chk("spur_cc", cnv_cmplt, 0);
            chk("spur_wrt", wrt, 0);
        end
        chk_regs("spur");
        chk("spur_busy", busy, 0);
        convert(16'($urandom), 16'($urandom), 5, 0);

        // reset mid-WAIT1 with nonzero registers and cmd
        resp_q.push_back(16'h0);
        resp_q.push_back(16'h0);
        lat = 20;
        @(negedge clk); nxt = 1'b1;
        @(negedge clk); nxt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk_regs("midrst");
        chk("midrst_wrt", wrt, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cmd", cmd, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        resp_q.delete();
        @(negedge clk);

        // full-scale twice on the left channel (averaging boundary when enabled)
        convert(16'($urandom), 16'h0FFF, 4, 0);
        convert(16'($urandom), 16'($urandom), 4, 0);
        convert(16'($urandom), 16'($urandom), 4, 0);
        convert(16'($urandom), 16'($urandom), 4, 0);
        convert(16'($urandom), 16'h0FFF, 4, 0);

        for (int k = 0; k < 20; k++)
            convert(16'($urandom), 16'($urandom), int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
